// File: rtl/lcd_page_buffer_pkg.sv
// Shared constants and state encoding for the LCD page buffer.
package lcd_page_buffer_pkg;

   localparam int LCD_COLS      = 64;
   localparam int ROWS_PER_PAGE = 8;
   localparam int MEM_AW        = 10;
   localparam int ROW_W         = 64;

   // Terminal counts: both counters wrap by compare against these, never by overflow.
   localparam logic [5:0] COL_LAST = 6'(LCD_COLS - 1);
   localparam logic [2:0] ROW_LAST = 3'(ROWS_PER_PAGE - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_ACK    = 2'd2,
      ST_STREAM = 2'd3
   } state_e;

endpackage

// File: rtl/page_transpose8.sv
// Maps one 64-bit ROM row onto the 64x8 page buffer: column c receives
// word bit (63-c) in bit position `row`. Produces a per-bit write enable
// plus the bit value each column should take.
module page_transpose8
   import lcd_page_buffer_pkg::*;
(
   input  logic                                       wr_en,
   input  logic [2:0]                                 row,
   input  logic [ROW_W-1:0]                           word,
   output logic [LCD_COLS-1:0][ROWS_PER_PAGE-1:0]     bit_en,
   output logic [LCD_COLS-1:0]                        col_bit
);

   // Column c takes word bit (63-c); only the addressed row of each column is enabled.
   always_comb begin
      bit_en  = '0;
      col_bit = '0;
      for (int c = 0; c < LCD_COLS; c++) begin
         col_bit[c] = word[ROW_W-1-c];
         bit_en[c]  = wr_en ? (8'b0000_0001 << row) : 8'b0000_0000;
      end
   end

endmodule

// File: rtl/lcd_page_buffer.sv
// LCD page buffer: on a page request, fetches eight 64-bit ROM rows,
// transposes them into 64 column bytes, acknowledges, and then streams
// the bytes (two cycles each) once the request is withdrawn.
//
// Handshake: data_request is a level from the controller. data_ack is a
// level that rises once the page is fully buffered and stays high while
// data_request stays high; the cycle after data_request is seen low in
// ACK, data_ack drops and streaming starts. Requests seen during STREAM
// are ignored; the first IDLE cycle after a stream samples data_request.
module lcd_page_buffer
   import lcd_page_buffer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              data_request,
   input  logic [6:0]        addr,
   output logic              data_ack,
   output logic [7:0]        data,
   output logic              mem_en,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [ROW_W-1:0]  mem_data,
   output logic [1:0]        fsm_state
);

   state_e state, state_nxt;

   logic              data_ack_nxt;
   logic [7:0]        data_nxt;
   logic              mem_en_nxt;
   logic [MEM_AW-1:0] mem_addr_nxt;

   // Read-return tracking: ROM data for the row issued last cycle arrives now.
   logic       rd_pend, rd_pend_nxt;
   logic [2:0] rd_row, rd_row_nxt;

   // Stream position: column counter and first/second cycle of the byte.
   logic [5:0] col_cnt, col_nxt;
   logic       phase, phase_nxt;

   logic [LCD_COLS-1:0][ROWS_PER_PAGE-1:0] page_buf;
   logic [LCD_COLS-1:0][ROWS_PER_PAGE-1:0] bit_en;
   logic [LCD_COLS-1:0]                    col_bit;
   logic                                   buf_wr;

   assign fsm_state = state;
   assign buf_wr    = (state == ST_FETCH) && rd_pend;

   page_transpose8 u_transpose (
      .wr_en   (buf_wr),
      .row     (rd_row),
      .word    (mem_data),
      .bit_en  (bit_en),
      .col_bit (col_bit)
   );

   // Page buffer: bit-granular writes from the transpose, no reset needed.
   always_ff @(posedge clk) begin
      for (int c = 0; c < LCD_COLS; c++) begin
         for (int k = 0; k < ROWS_PER_PAGE; k++) begin
            if (bit_en[c][k]) page_buf[c][k] <= col_bit[c];
         end
      end
   end

   // State, handshake, ROM interface and counters; all cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         data_ack <= 1'b0;
         data     <= 8'h00;
         mem_en   <= 1'b0;
         mem_addr <= '0;
         rd_pend  <= 1'b0;
         rd_row   <= 3'd0;
         col_cnt  <= 6'd0;
         phase    <= 1'b0;
      end else begin
         state    <= state_nxt;
         data_ack <= data_ack_nxt;
         data     <= data_nxt;
         mem_en   <= mem_en_nxt;
         mem_addr <= mem_addr_nxt;
         rd_pend  <= rd_pend_nxt;
         rd_row   <= rd_row_nxt;
         col_cnt  <= col_nxt;
         phase    <= phase_nxt;
      end
   end

   // Next-state and next-output decode for the fetch/ack/stream sequence.
   always_comb begin
      state_nxt    = state;
      data_ack_nxt = data_ack;
      data_nxt     = 8'h00;
      mem_en_nxt   = 1'b0;
      mem_addr_nxt = mem_addr;
      rd_pend_nxt  = mem_en;
      rd_row_nxt   = mem_addr[2:0];
      col_nxt      = col_cnt;
      phase_nxt    = phase;

      case (state)
         ST_IDLE: begin
            data_ack_nxt = 1'b0;
            if (data_request) begin
               state_nxt    = ST_FETCH;
               mem_en_nxt   = 1'b1;
               mem_addr_nxt = {addr, 3'b000};
            end
         end

         ST_FETCH: begin
            if (!data_request) begin
               // Withdrawn request aborts the fetch; the partial page is never acknowledged.
               state_nxt = ST_IDLE;
            end else begin
               if (mem_en && (mem_addr[2:0] != ROW_LAST)) begin
                  mem_en_nxt   = 1'b1;
                  mem_addr_nxt = {mem_addr[MEM_AW-1:3], mem_addr[2:0] + 3'd1};
               end
               if (rd_pend && (rd_row == ROW_LAST)) begin
                  state_nxt    = ST_ACK;
                  data_ack_nxt = 1'b1;
               end
            end
         end

         ST_ACK: begin
            if (!data_request) begin
               state_nxt    = ST_STREAM;
               data_ack_nxt = 1'b0;
               col_nxt      = 6'd0;
               phase_nxt    = 1'b0;
               data_nxt     = page_buf[6'd0];
            end
         end

         ST_STREAM: begin
            if (!phase) begin
               phase_nxt = 1'b1;
               data_nxt  = data;
            end else if (col_cnt == COL_LAST) begin
               state_nxt = ST_IDLE;
               col_nxt   = 6'd0;
               phase_nxt = 1'b0;
            end else begin
               col_nxt   = col_cnt + 6'd1;
               phase_nxt = 1'b0;
               data_nxt  = page_buf[col_cnt + 6'd1];
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_lcd_page_buffer.sv
// Self-checking bench for lcd_page_buffer: ROM model, golden transpose,
// table-driven pattern pages, abort/reset sequences and a back-to-back sweep.
module tb_lcd_page_buffer;
   import lcd_page_buffer_pkg::*;

   typedef struct {
      logic [6:0] addr;
      int         kind;
      logic [9:0] exp_ma0;
      logic [7:0] exp_b0;
      logic [7:0] exp_b1;
      logic [7:0] exp_b63;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        data_request;
   logic [6:0]  addr;
   logic        data_ack;
   logic [7:0]  data;
   logic        mem_en;
   logic [9:0]  mem_addr;
   logic [63:0] mem_data;
   logic [1:0]  fsm_state;

   int checks = 0;
   int errors = 0;

   logic [63:0] rom_mem [0:1023];
   logic [7:0]  exp_q[$];
   logic [7:0]  got_b [0:63];
   logic [9:0]  first_ma;
   vec_t        vecs [4];

   lcd_page_buffer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_request (data_request),
      .addr         (addr),
      .data_ack     (data_ack),
      .data         (data),
      .mem_en       (mem_en),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .fsm_state    (fsm_state)
   );

   // clock / ROM model (registered read, one cycle latency)
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) mem_data <= rom_mem[mem_addr];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Golden column byte: bit k of byte c is bit (63-c) of ROM row k.
   function automatic logic [7:0] golden_byte(input logic [6:0] a, input int c);
      logic [7:0]  b;
      logic [63:0] w;
      b = 8'h00;
      for (int k = 0; k < 8; k++) begin
         w    = rom_mem[{a, 3'(k)}];
         b[k] = w[63-c];
      end
      return b;
   endfunction

   task automatic fill_rom(input int kind, input logic [6:0] a);
      logic [63:0] ones01;
      ones01 = {8{8'h01}};
      for (int k = 0; k < 8; k++) begin
         case (kind)
            0:       rom_mem[{a, 3'(k)}] = ones01 << k;
            1:       rom_mem[{a, 3'(k)}] = 64'h8000_0000_0000_0000;
            2:       rom_mem[{a, 3'(k)}] = (k % 2 == 0) ? {16{4'hA}} : {16{4'h5}};
            3:       rom_mem[{a, 3'(k)}] = {64{1'b1}};
            default: rom_mem[{a, 3'(k)}] = {$urandom, $urandom};
         endcase
      end
   endtask

   // Entered at the negedge of cycle r; returns at the negedge of cycle r+10.
   task automatic fetch_phase(input logic [6:0] a);
      data_request = 1'b1;
      addr         = a;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) first_ma = mem_addr;
         check($sformatf("fetch_en_r%0d", i), 64'(mem_en), 64'd1);
         check($sformatf("fetch_addr_r%0d", i), 64'(mem_addr), 64'({a, 3'(i-1)}));
         check($sformatf("fetch_ack_r%0d", i), 64'(data_ack), 64'd0);
      end
      @(negedge clk);
      check("ack_low_r9", 64'(data_ack), 64'd0);
      check("en_low_r9", 64'(mem_en), 64'd0);
      @(negedge clk);
      check("ack_high_r10", 64'(data_ack), 64'd1);
      check("data_zero_r10", 64'(data), 64'd0);
   endtask

   task automatic hold_ack(input int n);
      repeat (n) begin
         @(negedge clk);
         check("ack_hold", 64'(data_ack), 64'd1);
         check("data_hold_zero", 64'(data), 64'd0);
      end
   endtask

   // Entered at the negedge of cycle h (request dropped here).
   task automatic stream(input logic [6:0] a, input int nbytes, input int raise_at,
                         input logic [6:0] next_a);
      logic [7:0] e;
      exp_q.delete();
      for (int c = 0; c < 64; c++) exp_q.push_back(golden_byte(a, c));
      data_request = 1'b0;
      for (int k = 0; k < nbytes; k++) begin
         e = exp_q.pop_front();
         for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            if (p == 0) got_b[k] = data;
            check($sformatf("byte%0d_cyc%0d", k, p), 64'(data), 64'(e));
            check($sformatf("stream_ctl%0d", k), 64'({data_ack, mem_en}), 64'd0);
            if (k == raise_at && p == 0) begin
               data_request = 1'b1;
               addr         = next_a;
            end
         end
      end
      if (nbytes == 64) begin
         @(negedge clk);
         check("stream_end_data", 64'(data), 64'd0);
         check("stream_end_ack", 64'(data_ack), 64'd0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: run did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n        = 1'b0;
      data_request = 1'b0;
      addr         = 7'h00;
      for (int i = 0; i < 1024; i++) rom_mem[i] = {$urandom, $urandom};

      vecs[0] = '{addr: 7'h0B, kind: 0, exp_ma0: 10'h058, exp_b0: 8'h80, exp_b1: 8'h40, exp_b63: 8'h01};
      vecs[1] = '{addr: 7'h22, kind: 1, exp_ma0: 10'h110, exp_b0: 8'hFF, exp_b1: 8'h00, exp_b63: 8'h00};
      vecs[2] = '{addr: 7'h45, kind: 2, exp_ma0: 10'h228, exp_b0: 8'h55, exp_b1: 8'hAA, exp_b63: 8'hAA};
      vecs[3] = '{addr: 7'h00, kind: 3, exp_ma0: 10'h000, exp_b0: 8'hFF, exp_b1: 8'hFF, exp_b63: 8'hFF};

      // reset state
      repeat (3) @(negedge clk);
      check("rst_ack", 64'(data_ack), 64'd0);
      check("rst_data", 64'(data), 64'd0);
      check("rst_en", 64'(mem_en), 64'd0);
      check("rst_maddr", 64'(mem_addr), 64'd0);
      check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("idle_data", 64'(data), 64'd0);
         check("idle_ctl", 64'({data_ack, mem_en}), 64'd0);
      end

      // table-driven pattern pages
      for (int v = 0; v < 4; v++) begin
         fill_rom(vecs[v].kind, vecs[v].addr);
         fetch_phase(vecs[v].addr);
         check($sformatf("vec%0d_ma0", v), 64'(first_ma), 64'(vecs[v].exp_ma0));
         hold_ack(int'($urandom_range(0, 3)));
         stream(vecs[v].addr, 64, -1, 7'h00);
         check($sformatf("vec%0d_b0", v), 64'(got_b[0]), 64'(vecs[v].exp_b0));
         check($sformatf("vec%0d_b1", v), 64'(got_b[1]), 64'(vecs[v].exp_b1));
         check($sformatf("vec%0d_b63", v), 64'(got_b[63]), 64'(vecs[v].exp_b63));
      end

      // abort: request dropped at r+5, new request at r+8
      data_request = 1'b1;
      addr         = 7'h13;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check($sformatf("abort_en_r%0d", i), 64'(mem_en), 64'd1);
      end
      data_request = 1'b0;
      @(negedge clk);
      check("abort_ack_r6", 64'(data_ack), 64'd0);
      @(negedge clk);
      check("abort_en_r7", 64'(mem_en), 64'd0);
      check("abort_ack_r7", 64'(data_ack), 64'd0);
      check("abort_data_r7", 64'(data), 64'd0);
      @(negedge clk);
      check("abort_ack_r8", 64'(data_ack), 64'd0);
      fill_rom(4, 7'h14);
      fetch_phase(7'h14);
      hold_ack(1);
      stream(7'h14, 64, -1, 7'h00);

      // reset pulse during stream byte 30
      fill_rom(4, 7'h21);
      fetch_phase(7'h21);
      stream(7'h21, 31, -1, 7'h00);
      rst_n = 1'b0;
      #1;
      check("mrst_ack", 64'(data_ack), 64'd0);
      check("mrst_data", 64'(data), 64'd0);
      check("mrst_en", 64'(mem_en), 64'd0);
      check("mrst_maddr", 64'(mem_addr), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("post_rst_data", 64'(data), 64'd0);
         check("post_rst_ctl", 64'({data_ack, mem_en}), 64'd0);
      end
      fill_rom(4, 7'h2A);
      fetch_phase(7'h2A);
      stream(7'h2A, 64, -1, 7'h00);

      // back-to-back: 9 images x 9 requests, randomized ROM, early re-raise
      for (int i = 0; i < 1024; i++) rom_mem[i] = {$urandom, $urandom};
      for (int img = 0; img < 9; img++) begin
         for (int p = 0; p < 9; p++) begin
            logic [6:0] a;
            logic [6:0] na;
            int         raise;
            a     = {4'(img), 3'(p % 8)};
            na    = (p < 8) ? {4'(img), 3'((p + 1) % 8)} : {4'(img + 1), 3'd0};
            raise = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 63)) : -1;
            fetch_phase(a);
            hold_ack(int'($urandom_range(0, 2)));
            stream(a, 64, raise, na);
         end
      end
      data_request = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
